shadow_write_queue: RTL and testbench

- Sits between the CPU bus (bank/addr/dout/we, qualified by fast_clk) and the 128 KB slow RAM (banks E0/E1).
- Detects CPU writes to shadowed video regions in banks 00/01, as selected by the SHADOW register ($C035).
- Queues each detected write in a small FIFO and replays it into slow RAM on 1 MHz slot strobes.
- Asserts stall so the CPU clocking logic can hold the CPU while the queue is full.

---
 rtl/shadow_write_queue.sv | 110 +++++++++++
 tb/tb_shadow_write_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_write_queue.sv
// Captures CPU writes to shadowed video regions in banks 00/01 and replays
// them into slow RAM (banks E0/E1) on 1 MHz slot strobes through a small FIFO.
module shadow_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          fast_clk,
   input  logic [7:0]    bank,
   input  logic [15:0]   addr,
   input  logic [7:0]    dout,
   input  logic          we,
   input  logic [7:0]    shadow,
   input  logic          slow_slot,
   output logic [16:0]   slow_addr,
   output logic [7:0]    slow_din,
   output logic          slow_wr,
   output logic          stall,
   output logic [AW:0]   level,
   output logic          overflow
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [24:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [AW:0]   count_next_s;
   logic          stall_r;
   logic          overflow_r;
   logic          slow_wr_r;
   logic [16:0]   slow_addr_r;
   logic [7:0]    slow_din_r;

   logic bank0_s, bank_ok_s, hires_ok_s;
   logic text1_s, text2_s, hgr1_s, hgr2_s, shr_s;
   logic hit_s, push_s, pop_s, drop_s;

   // A set shadow bit inhibits its region; aux-bank hires also needs shadow[4] clear.
   assign bank0_s    = (bank == 8'h00);
   assign bank_ok_s  = bank0_s | (bank == 8'h01);
   assign hires_ok_s = bank0_s | ~shadow[4];
   assign text1_s    = (addr[15:10] == 6'b000001) & ~shadow[0];
   assign text2_s    = (addr[15:10] == 6'b000010) & ~shadow[5];
   assign hgr1_s     = (addr[15:13] == 3'b001) & ~shadow[1] & hires_ok_s;
   assign hgr2_s     = (addr[15:13] == 3'b010) & ~shadow[2] & hires_ok_s;
   assign shr_s      = ~bank0_s & (addr >= 16'h2000) & (addr <= 16'h9FFF) & ~shadow[3];
   assign hit_s      = fast_clk & we & bank_ok_s & (text1_s | text2_s | hgr1_s | hgr2_s | shr_s);

   // An empty queue never bypasses: a same-cycle slot is ignored and the hit is stored.
   assign pop_s  = slow_slot & (count_r != '0);
   assign push_s = hit_s & ((count_r != FULL_LVL) | pop_s);
   assign drop_s = hit_s & (count_r == FULL_LVL) & ~pop_s;

   // Next occupancy from the push/pop combination
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + (AW+1)'(1);
         2'b01:   count_next_s = count_r - (AW+1)'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Entry storage; contents are meaningless after reset since level returns to 0
   always_ff @(posedge clk_sys) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {bank[0], addr, dout};
      end
   end

   // Pointers, occupancy, status flags and the slow-RAM write port
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         stall_r     <= 1'b0;
         overflow_r  <= 1'b0;
         slow_wr_r   <= 1'b0;
         slow_addr_r <= 17'h0_0000;
         slow_din_r  <= 8'h00;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r    <= rd_ptr_r + AW'(1);
            slow_addr_r <= mem_r[rd_ptr_r][24:8];
            slow_din_r  <= mem_r[rd_ptr_r][7:0];
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         count_r   <= count_next_s;
         stall_r   <= (count_next_s == FULL_LVL);
         slow_wr_r <= pop_s;
      end
   end

   assign slow_addr = slow_addr_r;
   assign slow_din  = slow_din_r;
   assign slow_wr   = slow_wr_r;
   assign stall     = stall_r;
   assign level     = count_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_shadow_write_queue.sv
// Directed self-checking bench for shadow_write_queue (DEPTH=4).
module tb_shadow_write_queue;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        fast_clk;
   logic [7:0]  bank;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic        we;
   logic [7:0]  shadow;
   logic        slow_slot;
   logic [16:0] slow_addr;
   logic [7:0]  slow_din;
   logic        slow_wr;
   logic        stall;
   logic [2:0]  level;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   shadow_write_queue #(.DEPTH(4), .AW(2)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .fast_clk  (fast_clk),
      .bank      (bank),
      .addr      (addr),
      .dout      (dout),
      .we        (we),
      .shadow    (shadow),
      .slow_slot (slow_slot),
      .slow_addr (slow_addr),
      .slow_din  (slow_din),
      .slow_wr   (slow_wr),
      .stall     (stall),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // One clock: present a bus cycle (optional) and slot, then sample 1 ns after the edge
   task automatic step(input logic fc, input logic w, input logic [7:0] b,
                       input logic [15:0] a, input logic [7:0] d, input logic sl);
      fast_clk  = fc;
      we        = w;
      bank      = b;
      addr      = a;
      dout      = d;
      slow_slot = sl;
      @(posedge clk_sys);
      #1;
      fast_clk  = 1'b0;
      we        = 1'b0;
      slow_slot = 1'b0;
   endtask

   task automatic wr(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d);
      step(1'b1, 1'b1, b, a, d, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
   endtask

   task automatic slot();
      step(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      idle();
   endtask

   task automatic check_drain(input string nm, input logic [16:0] ea, input logic [7:0] ed);
      slot();
      total++;
      if (slow_wr !== 1'b1 || slow_addr !== ea || slow_din !== ed) begin
         bad++;
         $display("FAIL %s: wr=%b addr=%h din=%h, want wr=1 addr=%h din=%h",
                  nm, slow_wr, slow_addr, slow_din, ea, ed);
      end
   endtask

   task automatic test_reset();
      shadow = 8'h00;
      for (int i = 0; i < 5; i++) wr(8'h00, 16'h0400 + 16'(i), 8'h10 + 8'(i));
      slot();
      total++;
      if (level !== 3'd3 || slow_wr !== 1'b1 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre: level=%0d wr=%b ovf=%b, want 3 1 1", level, slow_wr, overflow);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (level !== 3'd0 || stall !== 1'b0 || overflow !== 1'b0 || slow_wr !== 1'b0 ||
          slow_addr !== 17'h0_0000 || slow_din !== 8'h00) begin
         bad++;
         $display("FAIL reset_async: level=%0d stall=%b ovf=%b wr=%b addr=%h din=%h, want all 0",
                  level, stall, overflow, slow_wr, slow_addr, slow_din);
      end
      reset = 1'b0;
      idle();
   endtask

   task automatic test_text();
      shadow = 8'h00;
      wr(8'h00, 16'h0400, 8'hA5);
      total++;
      if (level !== 3'd1) begin
         bad++;
         $display("FAIL text_enq: level=%0d, want 1", level);
      end
      check_drain("text_drain", 17'h0_0400, 8'hA5);
      idle();
      total++;
      if (slow_wr !== 1'b0 || slow_addr !== 17'h0_0400 || level !== 3'd0) begin
         bad++;
         $display("FAIL text_hold: wr=%b addr=%h level=%0d, want 0 00400 0", slow_wr, slow_addr, level);
      end
      shadow = 8'h01;
      wr(8'h00, 16'h0400, 8'h11);
      step(1'b1, 1'b0, 8'h00, 16'h0800, 8'h22, 1'b0);
      wr(8'h02, 16'h0800, 8'h33);
      total++;
      if (level !== 3'd0) begin
         bad++;
         $display("FAIL text_inhibit: level=%0d, want 0", level);
      end
      wr(8'h00, 16'h0BFF, 8'h44);
      total++;
      if (level !== 3'd1) begin
         bad++;
         $display("FAIL text2_enq: level=%0d, want 1", level);
      end
      check_drain("text2_drain", 17'h0_0BFF, 8'h44);
   endtask

   task automatic test_shr();
      shadow = 8'h10;
      wr(8'h01, 16'h9000, 8'h3C);
      total++;
      if (level !== 3'd1) begin
         bad++;
         $display("FAIL shr_enq: level=%0d, want 1", level);
      end
      check_drain("shr_drain", 17'h1_9000, 8'h3C);
      shadow = 8'h18;
      wr(8'h01, 16'h2000, 8'h5A);
      total++;
      if (level !== 3'd0) begin
         bad++;
         $display("FAIL shr_inhibit: level=%0d, want 0", level);
      end
      wr(8'h00, 16'h2000, 8'h55);
      total++;
      if (level !== 3'd1) begin
         bad++;
         $display("FAIL hgr_bank0: level=%0d, want 1", level);
      end
      check_drain("hgr_drain", 17'h0_2000, 8'h55);
   endtask

   task automatic test_fill_drop();
      shadow = 8'h00;
      for (int i = 0; i < 4; i++) wr(8'h00, 16'h0400 + 16'(i), 8'h11 + 8'(i));
      total++;
      if (level !== 3'd4 || stall !== 1'b1 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL fill: level=%0d stall=%b ovf=%b, want 4 1 0", level, stall, overflow);
      end
      wr(8'h00, 16'h0404, 8'h15);
      total++;
      if (level !== 3'd4 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL drop: level=%0d ovf=%b, want 4 1", level, overflow);
      end
      check_drain("drain1", 17'h0_0400, 8'h11);
      total++;
      if (stall !== 1'b0 || level !== 3'd3) begin
         bad++;
         $display("FAIL stall_fall: stall=%b level=%0d, want 0 3", stall, level);
      end
      check_drain("drain2", 17'h0_0401, 8'h12);
      check_drain("drain3", 17'h0_0402, 8'h13);
      check_drain("drain4", 17'h0_0403, 8'h14);
      idle();
      total++;
      if (level !== 3'd0 || overflow !== 1'b1 || slow_wr !== 1'b0) begin
         bad++;
         $display("FAIL after_drain: level=%0d ovf=%b wr=%b, want 0 1 0", level, overflow, slow_wr);
      end
      do_reset();
   endtask

   task automatic test_full_push_pop();
      shadow = 8'h00;
      for (int i = 0; i < 4; i++) wr(8'h00, 16'h0400 + 16'(i), 8'h21 + 8'(i));
      step(1'b1, 1'b1, 8'h00, 16'h0405, 8'h25, 1'b1);
      total++;
      if (level !== 3'd4 || overflow !== 1'b0 || stall !== 1'b1 || slow_wr !== 1'b1 ||
          slow_addr !== 17'h0_0400 || slow_din !== 8'h21) begin
         bad++;
         $display("FAIL full_pp: level=%0d ovf=%b stall=%b wr=%b addr=%h din=%h, want 4 0 1 1 00400 21",
                  level, overflow, stall, slow_wr, slow_addr, slow_din);
      end
      check_drain("fpp_d2", 17'h0_0401, 8'h22);
      check_drain("fpp_d3", 17'h0_0402, 8'h23);
      check_drain("fpp_d4", 17'h0_0403, 8'h24);
      check_drain("fpp_d5", 17'h0_0405, 8'h25);
   endtask

   task automatic test_empty_push_slot();
      shadow = 8'h00;
      idle();
      step(1'b1, 1'b1, 8'h00, 16'h0406, 8'h66, 1'b1);
      total++;
      if (slow_wr !== 1'b0 || level !== 3'd1) begin
         bad++;
         $display("FAIL empty_ps: wr=%b level=%0d, want 0 1", slow_wr, level);
      end
      check_drain("empty_ps_drain", 17'h0_0406, 8'h66);
      slot();
      total++;
      if (slow_wr !== 1'b0 || level !== 3'd0) begin
         bad++;
         $display("FAIL empty_slot: wr=%b level=%0d, want 0 0", slow_wr, level);
      end
   endtask

   initial begin
      reset     = 1'b1;
      fast_clk  = 1'b0;
      we        = 1'b0;
      bank      = 8'h00;
      addr      = 16'h0000;
      dout      = 8'h00;
      shadow    = 8'h00;
      slow_slot = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      idle();
      test_reset();
      test_text();
      test_shr();
      test_fill_drop();
      test_full_push_pop();
      test_empty_push_slot();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
